// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder-tree datapath: default geometry, derived widths,
// a constant clog2 helper and the sequencer state encoding.
package adder_tree_pkg;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            v = v >>> 1;
            r = r + 1;
        end
        return r;
    endfunction

    localparam int DEF_N         = 16;
    localparam int DEF_K         = 8;
    localparam int DEF_TREE_LAT  = 6;
    localparam int DEF_MAX_BEATS = 255;

    localparam int SUM_W  = DEF_K + clog2(DEF_N);
    localparam int BEAT_W = clog2(DEF_MAX_BEATS + 1);
    localparam int ACC_W  = SUM_W + BEAT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Shift register that tags beats in flight through the tree so the accumulator
// knows which tree outputs are real sums and which are bubbles.
module valid_delay_line #(
    parameter int DEPTH = 6
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic in_valid,
    output logic out_valid,
    output logic any_busy
);

    logic [DEPTH-1:0] tag_r;

    // Shift one tag per cycle; a clear drops every tag so aborted beats never surface.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_r <= {DEPTH{1'b0}};
        end else if (clr) begin
            tag_r <= {DEPTH{1'b0}};
        end else begin
            tag_r <= (tag_r << 1) | {{(DEPTH-1){1'b0}}, in_valid};
        end
    end

    assign out_valid = tag_r[DEPTH-1];
    assign any_busy  = |tag_r;

endmodule

// File: rtl/adder_tree_accum_ctrl.sv
// Job sequencer for the pipelined adder tree: streams beats into the tree, tracks them
// with a latency-matched delay line and accumulates the tree sums into one total per job.
module adder_tree_accum_ctrl
    import adder_tree_pkg::*;
#(
    parameter int  N          = DEF_N,
    parameter int  K          = DEF_K,
    parameter int  TREE_LAT   = DEF_TREE_LAT,
    parameter int  MAX_BEATS  = DEF_MAX_BEATS,
    localparam int SUM_BITS   = K + clog2(N),
    localparam int BEAT_BITS  = clog2(MAX_BEATS + 1),
    localparam int ACC_BITS   = SUM_BITS + BEAT_BITS
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 abort,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [BEAT_BITS-1:0] cmd_beats,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [N*K-1:0]       s_data,
    output logic                 tree_in_valid,
    output logic [N*K-1:0]       tree_in_flat,
    input  logic [SUM_BITS-1:0]  tree_sum,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_BITS-1:0]  res_sum
);

    state_t               state_r;
    logic [ACC_BITS-1:0]  acc_r;
    logic [BEAT_BITS-1:0] beat_cnt_r;
    logic                 fire_s;
    logic                 dl_out_s;
    logic                 dl_busy_s;

    assign cmd_ready     = (state_r == IDLE) && !abort;
    assign s_ready       = (state_r == FEED) && !abort;
    assign fire_s        = s_valid && s_ready;
    assign tree_in_valid = fire_s;
    assign tree_in_flat  = s_data;
    assign res_valid     = (state_r == RESP);
    assign res_sum       = acc_r;

    valid_delay_line #(
        .DEPTH (TREE_LAT)
    ) u_delay (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (abort),
        .in_valid  (fire_s),
        .out_valid (dl_out_s),
        .any_busy  (dl_busy_s)
    );

    // Controller FSM, beat counter and accumulator; abort wins over everything else.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            acc_r      <= {ACC_BITS{1'b0}};
            beat_cnt_r <= {BEAT_BITS{1'b0}};
        end else if (abort) begin
            state_r    <= IDLE;
            acc_r      <= {ACC_BITS{1'b0}};
            beat_cnt_r <= {BEAT_BITS{1'b0}};
        end else begin
            if (dl_out_s) begin
                acc_r <= acc_r + {{(ACC_BITS-SUM_BITS){1'b0}}, tree_sum};
            end
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        acc_r      <= {ACC_BITS{1'b0}};
                        beat_cnt_r <= cmd_beats;
                        state_r    <= (cmd_beats == {BEAT_BITS{1'b0}}) ? RESP : FEED;
                    end
                end
                FEED: begin
                    if (fire_s) begin
                        beat_cnt_r <= beat_cnt_r - {{(BEAT_BITS-1){1'b0}}, 1'b1};
                        if (beat_cnt_r == {{(BEAT_BITS-1){1'b0}}, 1'b1}) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!dl_busy_s) begin
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_accum_ctrl.sv
// Directed bench for adder_tree_accum_ctrl with a behavioural 6-stage pipelined tree model.
module tb_adder_tree_accum_ctrl;

    localparam int N      = 16;
    localparam int K      = 8;
    localparam int LAT    = 6;
    localparam int SUM_W  = 12;
    localparam int BEAT_W = 8;
    localparam int ACC_W  = 20;

    logic              clk;
    logic              rstn;
    logic              abort;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [BEAT_W-1:0] cmd_beats;
    logic              s_valid;
    logic              s_ready;
    logic [N*K-1:0]    s_data;
    logic              tree_in_valid;
    logic [N*K-1:0]    tree_in_flat;
    logic [SUM_W-1:0]  tree_sum;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_sum;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tiv_count = 0;

    logic [SUM_W-1:0] tree_pipe [LAT];

    adder_tree_accum_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .abort         (abort),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_beats     (cmd_beats),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .tree_in_valid (tree_in_valid),
        .tree_in_flat  (tree_in_flat),
        .tree_sum      (tree_sum),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_sum       (res_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tree_in_valid) tiv_count <= tiv_count + 1;
    end

    function automatic logic [SUM_W-1:0] lane_sum(input logic [N*K-1:0] flat);
        logic [SUM_W-1:0] s;
        s = '0;
        for (int j = 0; j < N; j++) s = s + SUM_W'(flat[j*K +: K]);
        return s;
    endfunction

    // Pipelined tree model: sums whatever is on in_flat every cycle, bubbles included.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) tree_pipe[i] <= '0;
        end else begin
            tree_pipe[0] <= lane_sum(tree_in_flat);
            for (int i = 1; i < LAT; i++) tree_pipe[i] <= tree_pipe[i-1];
        end
    end
    assign tree_sum = tree_pipe[LAT-1];

    function automatic logic [N*K-1:0] beat_lanes(input int mode, input int b);
        logic [N*K-1:0] d;
        logic [K-1:0]   v;
        case (mode)
            0:       v = 8'hFF;
            1:       v = K'(b + 1);
            default: v = 8'h01;
        endcase
        for (int j = 0; j < N; j++) d[j*K +: K] = v;
        return d;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd_ready(input string tag);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check_value({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    // Runs one job: command, beats (optionally every other cycle), drain, then result handshake.
    task automatic run_job(input string tag, input int beats, input int mode, input int gap,
                           input int hold, input int exp_sum);
        int b;
        int n;
        int acc_cyc;
        int last_cyc;
        int tiv_start;
        int exp_cyc;
        wait_cmd_ready(tag);
        tiv_start = tiv_count;
        cmd_valid = 1'b1;
        cmd_beats = BEAT_W'(beats);
        #1;
        acc_cyc  = cyc;
        last_cyc = cyc;
        step();
        cmd_valid = 1'b0;
        b = 0;
        n = 0;
        while (b < beats && n < 1000) begin
            if (gap != 0 && (n % 2) == 1) begin
                s_valid = 1'b0;
                s_data  = beat_lanes(0, 0);
            end else begin
                s_valid = 1'b1;
                s_data  = beat_lanes(mode, b);
            end
            #1;
            if (tree_in_valid) begin
                b++;
                last_cyc = cyc;
            end
            step();
            n++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        check_value({tag, "_beats_fed"}, 32'(b), 32'(beats));
        n = 0;
        while (!res_valid && n < 50) begin
            step();
            n++;
        end
        check_value({tag, "_res_valid"}, 32'(res_valid), 32'd1);
        exp_cyc = (beats == 0) ? acc_cyc + 1 : last_cyc + LAT + 2;
        check_value({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check_value({tag, "_tree_in_valid_cnt"}, 32'(tiv_count - tiv_start), 32'(beats));
        for (int h = 0; h < hold; h++) begin
            check_value({tag, "_hold_sum"}, 32'(res_sum), 32'(exp_sum));
            check_value({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            check_value({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
            step();
        end
        res_ready = 1'b1;
        #1;
        check_value({tag, "_res_sum"}, 32'(res_sum), 32'(exp_sum));
        step();
        res_ready = 1'b0;
        check_value({tag, "_res_valid_drop"}, 32'(res_valid), 32'd0);
        check_value({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int n;
        int rv_seen;
        rstn      = 1'b0;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        cmd_beats = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        res_ready = 1'b0;
        #2;
        check_value("rst_res_valid", 32'(res_valid), 32'd0);
        check_value("rst_res_sum", 32'(res_sum), 32'd0);
        check_value("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_value("rst_s_ready", 32'(s_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step();

        run_job("t1_one_beat", 1, 0, 0, 0, 4080);
        run_job("t2_four_beats", 4, 1, 0, 0, 160);
        run_job("t3_gapped", 3, 2, 1, 0, 48);
        run_job("t4_zero_beats", 0, 2, 0, 0, 0);

        // abort with a command pending in IDLE must not take the command
        cmd_valid = 1'b1;
        cmd_beats = 8'd3;
        abort     = 1'b1;
        #1;
        check_value("abort_idle_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        #1;
        check_value("abort_idle_stays_idle", 32'(cmd_ready), 32'd1);
        check_value("abort_idle_s_ready", 32'(s_ready), 32'd0);

        // abort during DRAIN of a two-beat job
        cmd_valid = 1'b1;
        cmd_beats = 8'd2;
        step();
        cmd_valid = 1'b0;
        s_valid   = 1'b1;
        s_data    = beat_lanes(0, 0);
        step();
        step();
        s_valid = 1'b0;
        s_data  = '0;
        step();
        step();
        check_value("t5_drain_s_ready", 32'(s_ready), 32'd0);
        check_value("t5_drain_cmd_ready", 32'(cmd_ready), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        rv_seen = 0;
        for (n = 0; n < 20; n++) begin
            if (res_valid) rv_seen++;
            step();
        end
        check_value("t5_no_res_after_abort", 32'(rv_seen), 32'd0);
        run_job("t5_after_abort", 1, 2, 0, 0, 16);

        run_job("t6_max_backpressure", 255, 0, 0, 10, 1040400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
